reg_dest_tracker: RTL and testbench

//   Parametrised successor to the register-destination mux. Selects the write

---
 rtl/reg_dest_tracker.sv | 95 +++++++++
 tb/tb_reg_dest_tracker.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/reg_dest_tracker.sv
// Write-destination selector with a DEPTH-stage in-flight pipeline to write-back,
// a pending-write scoreboard and RAW hazard flags for the two decode operands.
module reg_dest_tracker #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 3,
  parameter int RA_REG = 31,
  parameter int SP_REG = 29
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   advance,
  input  logic                   flush,
  input  logic                   issue_valid,
  input  logic                   issue_we,
  input  logic [1:0]             dest_sel,
  input  logic [ADDR_W-1:0]      rt_addr,
  input  logic [ADDR_W-1:0]      rd_addr,
  input  logic [ADDR_W-1:0]      src_a_addr,
  input  logic [ADDR_W-1:0]      src_b_addr,
  output logic [ADDR_W-1:0]      dest_addr,
  output logic                   wb_valid,
  output logic [ADDR_W-1:0]      wb_addr,
  output logic [2**ADDR_W-1:0]   pending,
  output logic                   hazard_a,
  output logic                   hazard_b
);

  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LP_RA = ADDR_W'(RA_REG);
  localparam logic [ADDR_W-1:0] LP_SP = ADDR_W'(SP_REG);

  typedef enum logic [1:0] {
    SEL_RT = 2'b00,
    SEL_RD = 2'b01,
    SEL_RA = 2'b10,
    SEL_SP = 2'b11
  } dest_sel_e;

  logic [DEPTH-1:0]  r_v;
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [ADDR_W-1:0] w_dest_addr;
  logic              w_issue_live;
  logic [NREG-1:0]   w_pending;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_dest_addr = rt_addr;
    case (dest_sel_e'(dest_sel))
      SEL_RT: w_dest_addr = rt_addr;
      SEL_RD: w_dest_addr = rd_addr;
      SEL_RA: w_dest_addr = LP_RA;
      SEL_SP: w_dest_addr = LP_SP;
      default: w_dest_addr = rt_addr;
    endcase
  end

  // Register 0 is hard-wired, so a write to it never becomes a live entry.
  assign w_issue_live = issue_valid & issue_we & (w_dest_addr != '0);

  // NOTE: state is updated with non-blocking assignments so every stage samples
  // its predecessor's pre-edge value; blocking here would collapse the shift.
  // The address array is small and its reset value is observable on wb_addr,
  // so it is cleared along with the valid bits rather than left unreset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v <= '0;
      for (int k = 0; k < DEPTH; k++) r_addr[k] <= '0;
    end else if (flush) begin
      r_v <= '0;
    end else if (advance) begin
      for (int k = 1; k < DEPTH; k++) begin
        r_v[k]    <= r_v[k-1];
        r_addr[k] <= r_addr[k-1];
      end
      r_v[0]    <= w_issue_live;
      r_addr[0] <= w_dest_addr;
    end
  end

  // Duplicates simply OR together, so a bit drops only when its last copy retires.
  always_comb begin
    w_pending = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (r_v[k]) w_pending[r_addr[k]] = 1'b1;
    end
  end

  assign dest_addr = w_dest_addr;
  assign wb_valid  = r_v[DEPTH-1];
  assign wb_addr   = r_addr[DEPTH-1];
  assign pending   = w_pending;
  assign hazard_a  = w_pending[src_a_addr];
  assign hazard_b  = w_pending[src_b_addr];

endmodule

// File: tb/tb_reg_dest_tracker.sv
// Randomized bench for reg_dest_tracker: in-flight writes are modelled as a list
// of {register, age} records, aged once per advance and retired after DEPTH steps.
module tb_reg_dest_tracker;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 3;

  logic              clk = 1'b0;
  logic              reset, advance, flush, issue_valid, issue_we;
  logic [1:0]        dest_sel;
  logic [ADDR_W-1:0] rt_addr, rd_addr, src_a_addr, src_b_addr;
  logic [ADDR_W-1:0] dest_addr, wb_addr;
  logic              wb_valid, hazard_a, hazard_b;
  logic [31:0]       pending;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int addr;
    int age;
  } ent_t;

  ent_t inflight[$];

  always #5 clk = ~clk;

  reg_dest_tracker #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RA_REG(31), .SP_REG(29)) dut (
    .clk(clk), .reset(reset), .advance(advance), .flush(flush),
    .issue_valid(issue_valid), .issue_we(issue_we), .dest_sel(dest_sel),
    .rt_addr(rt_addr), .rd_addr(rd_addr),
    .src_a_addr(src_a_addr), .src_b_addr(src_b_addr),
    .dest_addr(dest_addr), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .pending(pending), .hazard_a(hazard_a), .hazard_b(hazard_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int model_dest(int sel, int rt, int rd);
    case (sel)
      0: return rt;
      1: return rd;
      2: return 31;
      default: return 29;
    endcase
  endfunction

  function automatic logic [31:0] model_pending();
    logic [31:0] p = '0;
    foreach (inflight[i]) p[inflight[i].addr] = 1'b1;
    return p;
  endfunction

  // The entry that has aged DEPTH-1 times is the one presented at write-back.
  function automatic int model_wb_idx();
    foreach (inflight[i]) if (inflight[i].age == DEPTH - 1) return i;
    return -1;
  endfunction

  task automatic model_edge();
    ent_t nq[$];
    int d;
    if (reset || flush) begin
      inflight.delete();
    end else if (advance) begin
      foreach (inflight[i]) begin
        if (inflight[i].age + 1 < DEPTH) nq.push_back('{inflight[i].addr, inflight[i].age + 1});
      end
      d = model_dest(dest_sel, rt_addr, rd_addr);
      if (issue_valid && issue_we && d != 0) nq.push_back('{d, 0});
      inflight = nq;
    end
  endtask

  task automatic check_state(input string ctx);
    logic [31:0] p;
    int w;
    p = model_pending();
    w = model_wb_idx();
    check({ctx, "_wb_valid"}, wb_valid, (w >= 0));
    if (w >= 0) check({ctx, "_wb_addr"}, wb_addr, inflight[w].addr);
    check({ctx, "_pending"}, pending, p);
    check({ctx, "_hazard_a"}, hazard_a, p[src_a_addr]);
    check({ctx, "_hazard_b"}, hazard_b, p[src_b_addr]);
  endtask

  // Apply one cycle of inputs, check the combinational mux, clock, then check state.
  task automatic cycle(input logic r, input logic f, input logic adv,
                       input logic iv, input logic we, input logic [1:0] sel,
                       input int rt, input int rd, input int sa, input int sb,
                       input string ctx);
    reset = r; flush = f; advance = adv; issue_valid = iv; issue_we = we;
    dest_sel = sel; rt_addr = rt[4:0]; rd_addr = rd[4:0];
    src_a_addr = sa[4:0]; src_b_addr = sb[4:0];
    #1;
    check({ctx, "_dest"}, dest_addr, model_dest(sel, rt, rd));
    @(posedge clk);
    model_edge();
    #1;
    check_state(ctx);
  endtask

  initial begin
    int r_sel, r_rt, r_rd, r_sa, r_sb;
    logic r_rst, r_fl, r_adv, r_iv, r_we;

    reset = 1'b1; advance = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_we = 1'b0;
    dest_sel = 2'b00; rt_addr = '0; rd_addr = '0; src_a_addr = '0; src_b_addr = '0;
    @(negedge clk);

    cycle(1, 0, 1, 1, 1, 2'b01, 3, 9, 9, 3, "rst0");
    cycle(1, 0, 1, 1, 1, 2'b01, 3, 9, 9, 3, "rst1");
    check("rst_wb_addr_zero", wb_addr, 0);

    // Single write to r9: visible on wb after the third edge only, hazard on A.
    cycle(0, 0, 1, 1, 1, 2'b01, 4, 9, 9, 0, "t2_e0");
    check("t2_e0_pend9", pending[9], 1);
    cycle(0, 0, 1, 0, 0, 2'b00, 0, 0, 9, 9, "t2_e1");
    cycle(0, 0, 1, 0, 0, 2'b00, 0, 0, 9, 0, "t2_e2");
    check("t2_e2_wb_valid", wb_valid, 1);
    check("t2_e2_wb_addr", wb_addr, 9);
    cycle(0, 0, 1, 0, 0, 2'b00, 0, 0, 9, 0, "t2_e3");
    check("t2_e3_pend9", pending[9], 0);

    // Fixed destinations, write to r0 and we=0 are never live.
    cycle(0, 0, 1, 1, 1, 2'b10, 1, 2, 31, 29, "t3_ra");
    cycle(0, 0, 1, 1, 1, 2'b11, 1, 2, 31, 29, "t3_sp");
    cycle(0, 0, 1, 1, 1, 2'b01, 1, 0, 0, 0, "t3_r0");
    cycle(0, 0, 1, 1, 0, 2'b01, 1, 6, 6, 0, "t3_we0");
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0, 2'b00, 0, 0, 6, 0, "t3_drain");

    // Duplicate writes to r5, then a 4-cycle stall with issue attempts ignored.
    cycle(0, 0, 1, 1, 1, 2'b00, 5, 0, 5, 5, "t5_a");
    cycle(0, 0, 1, 1, 1, 2'b00, 5, 0, 5, 5, "t5_b");
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 1, 2'b01, 0, 12, 12, 5, "t5_hold");
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0, 2'b00, 0, 0, 5, 0, "t5_drain");
    check("t5_pend5_gone", pending[5], 0);

    // Flush with a same-cycle issue to r7, also with advance low.
    cycle(0, 0, 1, 1, 1, 2'b01, 0, 8, 8, 7, "t6_pre");
    cycle(0, 1, 0, 1, 1, 2'b01, 0, 7, 8, 7, "t6_flush");
    check("t6_pending_zero", pending, 0);
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 1, 0, 0, 2'b00, 0, 0, 7, 8, "t6_after");

    // Random traffic over a small register window to force hazards and duplicates.
    for (int n = 0; n < 600; n++) begin
      r_rst = ($urandom_range(0, 59) == 0);
      r_fl  = ($urandom_range(0, 19) == 0);
      r_adv = ($urandom_range(0, 3) != 0);
      r_iv  = ($urandom_range(0, 4) != 0);
      r_we  = ($urandom_range(0, 5) != 0);
      r_sel = $urandom_range(0, 3);
      r_rt  = $urandom_range(0, 7);
      r_rd  = $urandom_range(0, 7);
      r_sa  = ($urandom_range(0, 7) == 0) ? 31 : $urandom_range(0, 7);
      r_sb  = ($urandom_range(0, 7) == 0) ? 29 : $urandom_range(0, 7);
      cycle(r_rst, r_fl, r_adv, r_iv, r_we, r_sel[1:0], r_rt, r_rd, r_sa, r_sb, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
